pipe_regs_fde: RTL and testbench

PIPE_REGS_FDE -- requirements
Module: pipe_regs_fde

---
 rtl/pipe_regs_fde.sv | 127 ++++++++++++
 tb/tb_pipe_regs_fde.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_regs_fde.sv
// F/D and D/E pipeline registers with stall/flush control and a sticky protocol flag.
// Define PIPE_REGS_PERF_CNT_EN to build the stall/bubble performance counters.
module pipe_regs_fde #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CTRL_W    = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              StallF,
  input  logic              StallD,
  input  logic              FlushD,
  input  logic              FlushE,
  input  logic [31:0]       PCNextF,
  input  logic [31:0]       InstrF,
  input  logic [31:0]       PCPlus4F,
  input  logic [CTRL_W-1:0] CtrlD,
  input  logic [31:0]       RD1D,
  input  logic [31:0]       RD2D,
  input  logic [31:0]       ImmExtD,
  input  logic [4:0]        Rs1D,
  input  logic [4:0]        Rs2D,
  input  logic [4:0]        RdD,
  output logic [31:0]       PCF,
  output logic [31:0]       InstrD,
  output logic [31:0]       PCD,
  output logic [31:0]       PCPlus4D,
  output logic              ValidD,
  output logic [CTRL_W-1:0] CtrlE,
  output logic [31:0]       RD1E,
  output logic [31:0]       RD2E,
  output logic [31:0]       ImmExtE,
  output logic [31:0]       PCE,
  output logic [31:0]       PCPlus4E,
  output logic [4:0]        Rs1E,
  output logic [4:0]        Rs2E,
  output logic [4:0]        RdE,
  output logic              ValidE,
  output logic              ProtoErr,
  output logic [31:0]       StallCnt,
  output logic [31:0]       BubbleCnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      PCF <= RESET_PC;
    end else if (!StallF) begin
      PCF <= PCNextF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || FlushD) begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (!StallD) begin
      InstrD   <= InstrF;
      PCD      <= PCF;
      PCPlus4D <= PCPlus4F;
      ValidD   <= 1'b1;
    end
  end

  // A bubble clears CtrlE too, so no write enable survives into E.
  always_ff @(posedge clk) begin
    if (rst || FlushE) begin
      CtrlE    <= '0;
      RD1E     <= '0;
      RD2E     <= '0;
      ImmExtE  <= '0;
      PCE      <= '0;
      PCPlus4E <= '0;
      Rs1E     <= '0;
      Rs2E     <= '0;
      RdE      <= '0;
      ValidE   <= 1'b0;
    end else begin
      CtrlE    <= CtrlD;
      RD1E     <= RD1D;
      RD2E     <= RD2D;
      ImmExtE  <= ImmExtD;
      PCE      <= PCD;
      PCPlus4E <= PCPlus4D;
      Rs1E     <= Rs1D;
      Rs2E     <= Rs2D;
      RdE      <= RdD;
      ValidE   <= ValidD;
    end
  end

  // Holding D while F advances would drop an instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      ProtoErr <= 1'b0;
    end else if (StallD && !StallF && !FlushD) begin
      ProtoErr <= 1'b1;
    end
  end

`ifdef PIPE_REGS_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] bubble_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (StallD && stall_cnt != 32'hFFFF_FFFF) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (FlushE && bubble_cnt != 32'hFFFF_FFFF) begin
        bubble_cnt <= bubble_cnt + 32'd1;
      end
    end
  end

  assign StallCnt  = stall_cnt;
  assign BubbleCnt = bubble_cnt;
`else
  assign StallCnt  = '0;
  assign BubbleCnt = '0;
`endif

endmodule

// File: tb/tb_pipe_regs_fde.sv
// Scoreboarded random/directed bench for pipe_regs_fde.
// A reference model predicts outputs per edge; a monitor pops and compares.
module tb_pipe_regs_fde;
  localparam int CW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, StallF, StallD, FlushD, FlushE;
  logic [31:0] PCNextF, InstrF, PCPlus4F;
  logic [CW-1:0] CtrlD;
  logic [31:0] RD1D, RD2D, ImmExtD;
  logic [4:0] Rs1D, Rs2D, RdD;
  logic [31:0] PCF, InstrD, PCD, PCPlus4D;
  logic ValidD;
  logic [CW-1:0] CtrlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0] Rs1E, Rs2E, RdE;
  logic ValidE, ProtoErr;
  logic [31:0] StallCnt, BubbleCnt;

  pipe_regs_fde dut (
    .clk(clk), .rst(rst),
    .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .FlushE(FlushE),
    .PCNextF(PCNextF), .InstrF(InstrF), .PCPlus4F(PCPlus4F),
    .CtrlD(CtrlD), .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .ValidD(ValidD), .CtrlE(CtrlE), .RD1E(RD1E), .RD2E(RD2E),
    .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ValidE(ValidE),
    .ProtoErr(ProtoErr), .StallCnt(StallCnt), .BubbleCnt(BubbleCnt)
  );

  typedef struct {
    logic [31:0] pcf, instrd, pcd, pcp4d;
    logic vd;
    logic [CW-1:0] ctrle;
    logic [31:0] rd1e, rd2e, imme, pce, pcp4e;
    logic [4:0] rs1e, rs2e, rde;
    logic ve, perr;
    logic [31:0] sc, bc;
  } st_t;

  st_t m;
  st_t q[$];
  st_t e;
  int tests = 0;
  int fails = 0;

  task automatic chk(string nm, logic [63:0] a, logic [63:0] x);
    tests++;
    if (a !== x) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, a, x);
    end
  endtask

  // Cycle-level reference: what every output must read after this edge.
  function automatic st_t step(st_t s);
    st_t n;
    logic perf;
`ifdef PIPE_REGS_PERF_CNT_EN
    perf = 1'b1;
`else
    perf = 1'b0;
`endif
    n = s;
    if (rst) begin
      n = '{pcf: 32'h0, instrd: 32'h13, pcd: 0, pcp4d: 0, vd: 0,
            ctrle: 0, rd1e: 0, rd2e: 0, imme: 0, pce: 0, pcp4e: 0,
            rs1e: 0, rs2e: 0, rde: 0, ve: 0, perr: 0, sc: 0, bc: 0};
      return n;
    end
    if (!StallF) n.pcf = PCNextF;
    if (FlushD) begin
      n.instrd = 32'h13; n.pcd = 0; n.pcp4d = 0; n.vd = 0;
    end else if (!StallD) begin
      n.instrd = InstrF; n.pcd = s.pcf; n.pcp4d = PCPlus4F; n.vd = 1;
    end
    if (FlushE) begin
      n.ctrle = 0; n.rd1e = 0; n.rd2e = 0; n.imme = 0; n.pce = 0;
      n.pcp4e = 0; n.rs1e = 0; n.rs2e = 0; n.rde = 0; n.ve = 0;
    end else begin
      n.ctrle = CtrlD; n.rd1e = RD1D; n.rd2e = RD2D; n.imme = ImmExtD;
      n.pce = s.pcd; n.pcp4e = s.pcp4d; n.rs1e = Rs1D; n.rs2e = Rs2D;
      n.rde = RdD; n.ve = s.vd;
    end
    if (StallD && !StallF && !FlushD) n.perr = 1;
    if (perf && StallD && s.sc != 32'hFFFF_FFFF) n.sc = s.sc + 1;
    if (perf && FlushE && s.bc != 32'hFFFF_FFFF) n.bc = s.bc + 1;
    return n;
  endfunction

  task automatic cyc(logic r, logic sf, logic sd, logic fd, logic fe,
                     logic [31:0] pcn, logic [31:0] ins);
    @(negedge clk);
    rst = r; StallF = sf; StallD = sd; FlushD = fd; FlushE = fe;
    PCNextF = pcn; InstrF = ins; PCPlus4F = m.pcf + 32'd4;
    CtrlD = CW'($urandom); RD1D = $urandom; RD2D = $urandom;
    ImmExtD = $urandom; Rs1D = 5'($urandom); Rs2D = 5'($urandom);
    RdD = 5'($urandom);
    m = step(m);
    q.push_back(m);
  endtask

  task automatic run(logic sf, logic sd, logic fd, logic fe);
    cyc(1'b0, sf, sd, fd, fe, m.pcf + 32'd4, $urandom);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("PCF", PCF, e.pcf);
      chk("InstrD", InstrD, e.instrd);
      chk("PCD", PCD, e.pcd);
      chk("PCPlus4D", PCPlus4D, e.pcp4d);
      chk("ValidD", ValidD, e.vd);
      chk("CtrlE", CtrlE, e.ctrle);
      chk("RD1E", RD1E, e.rd1e);
      chk("RD2E", RD2E, e.rd2e);
      chk("ImmExtE", ImmExtE, e.imme);
      chk("PCE", PCE, e.pce);
      chk("PCPlus4E", PCPlus4E, e.pcp4e);
      chk("Rs1E", Rs1E, e.rs1e);
      chk("Rs2E", Rs2E, e.rs2e);
      chk("RdE", RdE, e.rde);
      chk("ValidE", ValidE, e.ve);
      chk("ProtoErr", ProtoErr, e.perr);
      chk("StallCnt", StallCnt, e.sc);
      chk("BubbleCnt", BubbleCnt, e.bc);
    end
  end

  initial begin
    logic [31:0] held_pc;
    rst = 1; StallF = 0; StallD = 0; FlushD = 0; FlushE = 0;
    PCNextF = 0; InstrF = 0; PCPlus4F = 0; CtrlD = 0;
    RD1D = 0; RD2D = 0; ImmExtD = 0; Rs1D = 0; Rs2D = 0; RdD = 0;
    m = '{default: '0};

    // reset, then three free-running cycles
    cyc(1, 0, 0, 0, 0, 0, 32'h1111_1111);
    after_edge();
    chk("rst_pcf", PCF, 32'h0);
    chk("rst_instrd", InstrD, 32'h13);
    run(0, 0, 0, 0);
    after_edge();
    chk("run1_pcf", PCF, 32'h4);
    run(0, 0, 0, 0);
    run(0, 0, 0, 0);
    after_edge();
    chk("run3_pcf", PCF, 32'hC);
    chk("run3_valide", ValidE, 1'b1);

    // load-use
    cyc(0, 0, 0, 0, 0, m.pcf + 4, 32'h0000_2083);
    after_edge();
    held_pc = PCF;
    run(1, 1, 0, 1);
    after_edge();
    chk("lu_instrd", InstrD, 32'h0000_2083);
    chk("lu_pcf", PCF, held_pc);
    chk("lu_ctrle", CtrlE, 0);
    chk("lu_valide", ValidE, 0);
    run(0, 0, 0, 0);

    // branch taken
    cyc(0, 0, 0, 1, 1, 32'h100, $urandom);
    after_edge();
    chk("br_pcf", PCF, 32'h100);
    chk("br_instrd", InstrD, 32'h13);
    chk("br_validd", ValidD, 0);
    chk("br_valide", ValidE, 0);

    // protocol violation is sticky
    run(0, 1, 0, 0);
    for (int i = 0; i < 10; i++) run(0, 0, 0, 0);
    after_edge();
    chk("perr_sticky", ProtoErr, 1);

    // reset during load-use
    cyc(1, 1, 1, 0, 1, 32'h40, $urandom);
    after_edge();
    chk("rst_mid_pcf", PCF, 0);
    chk("rst_mid_perr", ProtoErr, 0);
    chk("rst_mid_valide", ValidE, 0);

    // perf counters
    for (int i = 0; i < 5; i++) run(1, 1, 0, 0);
    for (int i = 0; i < 3; i++) run(0, 0, 0, 1);
    after_edge();
`ifdef PIPE_REGS_PERF_CNT_EN
    chk("perf_stall", StallCnt, 5);
    chk("perf_bubble", BubbleCnt, 3);
`else
    chk("perf_stall", StallCnt, 0);
    chk("perf_bubble", BubbleCnt, 0);
`endif

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 49) == 0),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0),
          $urandom, $urandom);
    end

    after_edge();
    after_edge();
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
